// File: rtl/timer_apb_slave.sv
// APB3 register file for the 8-bit timer: TDR/TCR/TSR/TCNT/TIER decode,
// timer control outputs and sticky overflow/underflow status with interrupt.
//   state  | meaning
//   IDLE   | no transfer; a setup phase seen here starts one
//   ACCESS | transfer in progress, counting wait cycles until pready
module timer_apb_slave #(
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] TDR_RST     = 8'h00
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] tdr,
    output logic       load,
    output logic       dw,
    output logic       en,
    output logic [1:0] clk_sel,
    input  logic [7:0] cnt,
    input  logic       ovf_evt,
    input  logic       udf_evt,
    output logic       irq
);

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state;
    logic [2:0] wcnt;
    logic [2:0] wcnt_inc;
    logic [7:0] tcr;
    logic [1:0] tsr;
    logic [1:0] tier;
    logic       setup_seen;
    logic       resp_err;
    logic [7:0] rd_mux;
    logic [7:0] resp_data;
    logic       commit;

    assign setup_seen = psel & ~penable;
    assign wcnt_inc   = wcnt + 3'd1;

    always_comb begin
        resp_err = (paddr > 8'h04) || (pwrite && (paddr == 8'h03));
        rd_mux   = 8'h00;
        case (paddr)
            8'h00:   rd_mux = tdr;
            8'h01:   rd_mux = tcr;
            8'h02:   rd_mux = {6'b0, tsr};
            8'h03:   rd_mux = cnt;
            8'h04:   rd_mux = {6'b0, tier};
            default: rd_mux = 8'h00;
        endcase
        resp_data = (pwrite || resp_err) ? 8'h00 : rd_mux;
    end

    // Response is loaded on the edge entering the pready cycle, so TCNT is sampled there.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state   <= IDLE;
            wcnt    <= 3'd0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    prdata  <= 8'h00;
                    wcnt    <= 3'd0;
                    if (setup_seen) begin
                        state <= ACCESS;
                        if (WS == 3'd0) begin
                            pready  <= 1'b1;
                            pslverr <= resp_err;
                            prdata  <= resp_data;
                        end
                    end
                end
                ACCESS: begin
                    if (pready || !psel) begin
                        state   <= IDLE;
                        wcnt    <= 3'd0;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= 8'h00;
                    end else begin
                        wcnt <= wcnt_inc;
                        if (wcnt_inc == WS) begin
                            pready  <= 1'b1;
                            pslverr <= resp_err;
                            prdata  <= resp_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign commit = pready & pwrite & ~pslverr;

    // Event pulses OR in after the clear so a same-edge event always survives.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= TDR_RST;
            tcr  <= 8'h00;
            tsr  <= 2'b00;
            tier <= 2'b00;
        end else begin
            if (commit && paddr == 8'h00) tdr  <= pwdata;
            if (commit && paddr == 8'h01) tcr  <= pwdata & 8'hB3;
            if (commit && paddr == 8'h04) tier <= pwdata[1:0];
            tsr <= ((commit && paddr == 8'h02) ? (tsr & pwdata[1:0]) : tsr)
                   | {udf_evt, ovf_evt};
        end
    end

    assign load    = tcr[7];
    assign dw      = tcr[5];
    assign en      = tcr[4];
    assign clk_sel = tcr[1:0];
    assign irq     = |(tsr & tier);

endmodule

// File: tb/tb_timer_apb_slave.sv
// Bench for timer_apb_slave: a zero-wait instance and a three-wait instance
// share the bus; expected responses go through a scoreboard queue.
module tb_timer_apb_slave;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel0, psel3, penable, pwrite;
    logic [7:0] paddr, pwdata, cnt;
    logic       ovf_evt, udf_evt;

    logic [7:0] prdata0, prdata3, tdr0, tdr3;
    logic       pready0, pready3, pslverr0, pslverr3;
    logic       load0, load3, dw0, dw3, en0, en3, irq0, irq3;
    logic [1:0] clk_sel0, clk_sel3;

    always #5 pclk = ~pclk;

    timer_apb_slave #(.WAIT_STATES(0), .TDR_RST(8'h3C)) dut0 (
        .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
        .pready(pready0), .pslverr(pslverr0), .tdr(tdr0), .load(load0),
        .dw(dw0), .en(en0), .clk_sel(clk_sel0), .cnt(cnt),
        .ovf_evt(ovf_evt), .udf_evt(udf_evt), .irq(irq0));

    timer_apb_slave #(.WAIT_STATES(3)) dut3 (
        .pclk(pclk), .presetn(presetn), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3), .tdr(tdr3), .load(load3),
        .dw(dw3), .en(en3), .clk_sel(clk_sel3), .cnt(cnt),
        .ovf_evt(ovf_evt), .udf_evt(udf_evt), .irq(irq3));

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        logic       err;
        logic [7:0] tdr_e;
        logic [4:0] ctl_e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apb(input bit which, input logic wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input logic [7:0] rd,
                       input logic err, input logic [1:0] evt);
        exp_t e;
        exp_t got;
        int   lat;
        bit   done;
        @(posedge pclk); #1;
        if (which) psel3 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        e.rd  = wr ? 8'h00 : rd;
        e.err = err;
        e.lat = which ? 3 : 0;
        sb.push_back(e);
        @(posedge pclk); #1 penable = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge pclk);
            if (which ? pready3 : pready0) begin
                done = 1'b1;
                got  = sb.pop_front();
                check("latency", 32'(lat), 32'(got.lat));
                check("pslverr", 32'(which ? pslverr3 : pslverr0), 32'(got.err));
                if (!wr) check("prdata", 32'(which ? prdata3 : prdata0), 32'(got.rd));
                {udf_evt, ovf_evt} = evt;
            end else begin
                lat++;
            end
        end
        if (!done) begin
            check("pready_timeout", 32'(0), 32'(1));
            got = sb.pop_front();
        end
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        {udf_evt, ovf_evt} = 2'b00;
        @(negedge pclk);
        check("pready_one_cycle", 32'(which ? pready3 : pready0), 32'(0));
    endtask

    task automatic pulse(input logic [1:0] evt);
        @(posedge pclk); #1 {udf_evt, ovf_evt} = evt;
        @(posedge pclk); #1 {udf_evt, ovf_evt} = 2'b00;
    endtask

    vec_t vecs[18];

    initial begin
        // ctl_e = {load, dw, en, clk_sel}
        vecs[0]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 8'hFF, 5'b00000};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'hFF, 5'b00000};
        vecs[2]  = '{1'b1, 8'h01, 8'h80, 8'h00, 1'b0, 8'hFF, 5'b10000};
        vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h80, 1'b0, 8'hFF, 5'b10000};
        vecs[4]  = '{1'b1, 8'h01, 8'h31, 8'h00, 1'b0, 8'hFF, 5'b01101};
        vecs[5]  = '{1'b0, 8'h01, 8'h00, 8'h31, 1'b0, 8'hFF, 5'b01101};
        vecs[6]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 1'b0, 8'hFF, 5'b11111};
        vecs[7]  = '{1'b0, 8'h01, 8'h00, 8'hB3, 1'b0, 8'hFF, 5'b11111};
        vecs[8]  = '{1'b1, 8'h04, 8'hFF, 8'h00, 1'b0, 8'hFF, 5'b11111};
        vecs[9]  = '{1'b0, 8'h04, 8'h00, 8'h03, 1'b0, 8'hFF, 5'b11111};
        vecs[10] = '{1'b1, 8'h04, 8'h00, 8'h00, 1'b0, 8'hFF, 5'b11111};
        vecs[11] = '{1'b0, 8'h03, 8'h00, 8'h96, 1'b0, 8'hFF, 5'b11111};
        vecs[12] = '{1'b1, 8'h03, 8'h55, 8'h00, 1'b1, 8'hFF, 5'b11111};
        vecs[13] = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 8'hFF, 5'b11111};
        vecs[14] = '{1'b1, 8'h07, 8'hAA, 8'h00, 1'b1, 8'hFF, 5'b11111};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'hFF, 5'b11111};
        vecs[16] = '{1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 8'hFF, 5'b00000};
        vecs[17] = '{1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 8'hFF, 5'b00000};

        presetn = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00; cnt = 8'h96;
        ovf_evt = 1'b0; udf_evt = 1'b0;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        check("rst_pready", 32'(pready0), 32'(0));
        check("rst_prdata", 32'(prdata0), 32'(0));
        check("rst_pslverr", 32'(pslverr0), 32'(0));
        check("rst_irq", 32'(irq0), 32'(0));
        check("rst_tdr", 32'(tdr0), 32'h3C);
        check("rst_ctl", 32'({load0, dw0, en0, clk_sel0}), 32'(0));
        check("rst_tdr_ws3", 32'(tdr3), 32'h00);

        // Reset lands in the pready cycle of a TDR write: nothing commits.
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h5A;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        check("midxfer_pready", 32'(pready0), 32'(1));
        presetn = 1'b0;
        #1;
        check("midxfer_rst_pready", 32'(pready0), 32'(0));
        check("midxfer_rst_tdr", 32'(tdr0), 32'h3C);
        psel0 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 presetn = 1'b1;
        apb(1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0, 2'b00);

        // Access phase without a preceding setup is ignored.
        @(posedge pclk); #1;
        psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h11;
        begin
            logic seen;
            seen = 1'b0;
            repeat (3) begin
                @(negedge pclk);
                if (pready0) seen = 1'b1;
            end
            check("penable_no_setup", 32'(seen), 32'(0));
        end
        @(posedge pclk); #1 psel0 = 1'b0; penable = 1'b0;
        check("penable_no_setup_tdr", 32'(tdr0), 32'h3C);

        for (int i = 0; i < 18; i++) begin
            apb(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].err, 2'b00);
            check("vec_tdr", 32'(tdr0), 32'(vecs[i].tdr_e));
            check("vec_ctl", 32'({load0, dw0, en0, clk_sel0}), 32'(vecs[i].ctl_e));
        end

        pulse(2'b10);
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 2'b00);
        check("irq_masked", 32'(irq0), 32'(0));
        apb(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00);
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00);
        pulse(2'b10);
        apb(1'b0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 2'b00);
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 2'b00);
        apb(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 2'b01);
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 2'b00);
        apb(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00);
        pulse(2'b11);
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h03, 1'b0, 2'b00);

        apb(1'b0, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0, 2'b00);
        apb(1'b0, 1'b1, 8'h04, 8'h02, 8'h00, 1'b0, 2'b00);
        check("irq_clear", 32'(irq0), 32'(0));
        pulse(2'b01);
        check("irq_ovf_masked", 32'(irq0), 32'(0));
        pulse(2'b10);
        check("irq_udf", 32'(irq0), 32'(1));
        apb(1'b0, 1'b1, 8'h02, 8'h01, 8'h00, 1'b0, 2'b00);
        check("irq_drop", 32'(irq0), 32'(0));
        apb(1'b0, 1'b0, 8'h02, 8'h00, 8'h01, 1'b0, 2'b00);

        cnt = 8'hA7;
        apb(1'b1, 1'b0, 8'h03, 8'h00, 8'hA7, 1'b0, 2'b00);
        apb(1'b1, 1'b1, 8'h00, 8'h42, 8'h00, 1'b0, 2'b00);
        check("ws3_tdr", 32'(tdr3), 32'h42);
        apb(1'b1, 1'b0, 8'h07, 8'h00, 8'h00, 1'b1, 2'b00);
        apb(1'b1, 1'b1, 8'h03, 8'h55, 8'h00, 1'b1, 2'b00);
        apb(1'b1, 1'b1, 8'h07, 8'h99, 8'h00, 1'b1, 2'b00);
        check("ws3_tdr_after_err", 32'(tdr3), 32'h42);
        apb(1'b1, 1'b0, 8'h00, 8'h00, 8'h42, 1'b0, 2'b00);
        apb(1'b1, 1'b0, 8'h03, 8'h00, 8'hA7, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
